// File: rtl/alu_n_pkg.sv
// Shared opcodes, reserved-op boundary and FSM state encoding for the sequential N-bit ALU.
package alu_n_pkg;

  localparam logic [3:0] OP_NOTA = 4'b0000;
  localparam logic [3:0] OP_NOTB = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_SAR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  // Opcodes at or above this value are reserved and produce a zero result.
  localparam logic [3:0] OP_RSVD_LO = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_n_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per step, 2*WIDTH-bit product.
module alu_n_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // product already includes the step being taken this cycle, so the final
  // step and the load of the result can share one edge.
  always_comb begin
    product = acc + (mplier[0] ? mcand : '0);
    done    = step && (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_n_seq.sv
// Registered N-bit flag ALU with valid/ready handshake and an iterative MUL.
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
import alu_n_pkg::*;

module alu_n_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE and out_valid only in DONE, so
  // at most one operation is ever in flight.
  state_t state, state_next;

  logic                 mul_start, mul_step, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic                 mul_hi;
  logic                 load_alu, load_mul;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic [SW-1:0]        shamt;
  logic                 big_shift;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shl_ext, shr_ext, sar_ext;

  alu_n_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_hi = |mul_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = (op == OP_MUL) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    mul_start = (state == ST_IDLE) && in_valid && (op == OP_MUL);
    mul_step  = (state == ST_BUSY);
    load_alu  = (state == ST_IDLE) && in_valid && (op != OP_MUL);
    load_mul  = (state == ST_BUSY) && mul_done;
  end

  // Shift carries come from widening by one bit so the last bit shifted out
  // lands in the extra position; a zero shift leaves that bit clear.
  always_comb begin
    shamt     = b[SW-1:0];
    big_shift = (b >= WIDTH'(WIDTH));
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    shl_ext   = {1'b0, a} << shamt;
    shr_ext   = {a, 1'b0} >> shamt;
    sar_ext   = $signed({a, 1'b0}) >>> shamt;
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op)
      OP_NOTA: alu_res = ~a;
      OP_NOTB: alu_res = ~b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (alu_v) alu_res = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
      end
      OP_SHL: if (!big_shift) {alu_c, alu_res} = shl_ext;
      OP_SHR: if (!big_shift) {alu_res, alu_c} = shr_ext;
      OP_SAR: begin
        if (big_shift) alu_res = {WIDTH{a[WIDTH-1]}};
        else           {alu_res, alu_c} = sar_ext;
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
    end else if (load_alu) begin
      result <= alu_res;
      c      <= alu_c;
      n      <= alu_res[WIDTH-1];
      z      <= (alu_res == '0);
      v      <= alu_v;
    end else if (load_mul) begin
      result <= mul_prod[WIDTH-1:0];
      c      <= mul_hi;
      n      <= mul_prod[WIDTH-1];
      z      <= (mul_prod[WIDTH-1:0] == '0);
      v      <= mul_hi;
    end
  end

endmodule

// File: tb/tb_alu_n_seq.sv
// Bench for alu_n_seq: directed corner cases, random ops against an arithmetic model, handshake and reset checks.
module tb_alu_n_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         c, n, z, v;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;

  logic [W+3:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  alu_n_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic; returns {c, n, z, v, result}.
  function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, sx, sy, t, full, maxs, mins;
    logic [W-1:0] r;
    logic cf, vf;
    full = longint'(1) << W;
    maxs = full / 2 - 1;
    mins = -(full / 2);
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - full : ux;
    sy = y[W-1] ? uy - full : uy;
    r = '0; cf = 1'b0; vf = 1'b0; t = 0;
    case (o)
      4'd0: r = ~x;
      4'd1: r = ~y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~(x ^ y);
      4'd6, 4'd7: begin
        t  = (o == 4'd6) ? sx + sy : sx - sy;
        r  = (o == 4'd6) ? W'(ux + uy) : W'(ux - uy);
        cf = (o == 4'd6) ? ((ux + uy) >= full) : (ux >= uy);
        vf = (t > maxs) || (t < mins);
`ifdef ALU_SAT_EN
        if (vf) r = (t > 0) ? W'(maxs) : W'(mins);
`endif
      end
      4'd8, 4'd9, 4'd10: begin
        if (uy == 0)       r = x;
        else if (uy >= W)  r = (o == 4'd10 && x[W-1]) ? '1 : '0;
        else if (o == 4'd8) begin
          r  = W'(ux << uy);
          cf = ((ux >> (W - uy)) & 1) != 0;
        end else begin
          r  = (o == 4'd9) ? W'(ux >> uy) : W'(sx >>> uy);
          cf = ((ux >> (uy - 1)) & 1) != 0;
        end
      end
      4'd11: begin
        t  = ux * uy;
        r  = W'(t);
        cf = (t >> W) != 0;
        vf = cf;
      end
      default: r = '0;
    endcase
    return {cf, r[W-1], (r == '0), vf, r};
  endfunction

  // driver: present an op for one edge, then scramble inputs
  task automatic drive_accept(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W+3:0] e);
    check_val("in_ready_idle", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(e);
    a = W'($urandom); b = W'($urandom); op = 4'($urandom);
  endtask

  task automatic wait_result(input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      check_val("busy_in_ready", in_ready, 0);
      tick();
      lat++;
    end
    check_val("latency", lat, exp_lat);
  endtask

  // scoreboard
  task automatic check_outputs();
    logic [W+3:0] e;
    check_val("queue_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("result", result, e[W-1:0]);
      check_val("flags_cnzv", {c, n, z, v}, e[W+3:W]);
    end
  endtask

  task automatic consume(input int hold);
    logic [W-1:0] r0;
    check_outputs();
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      tick();
      check_val("hold_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      check_val("hold_result", result, r0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("post_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
    check_val("post_result", result, r0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_result"}, result, 0);
    check_val({tag, "_flags"}, {c, n, z, v}, 0);
  endtask

  // directed table: op, a, b, expected {c,n,z,v,result}, hold cycles
  logic [3:0]   d_op  [11] = '{4'h6, 4'h7, 4'h7, 4'h8, 4'hA, 4'h9, 4'hB, 4'hB, 4'h2, 4'hD, 4'h0};
  logic [W-1:0] d_a   [11] = '{8'h7F, 8'h05, 8'h00, 8'h81, 8'h80, 8'h01, 8'h10, 8'h0F, 8'hF0, 8'h12, 8'h0F};
  logic [W-1:0] d_b   [11] = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h03, 8'h09, 8'h10, 8'h03, 8'h3C, 8'h34, 8'h00};
`ifdef ALU_SAT_EN
  logic [W+3:0] d_exp [11] = '{12'h17F, 12'hA00, 12'h4FF, 12'h802, 12'h4F0, 12'h200,
                               12'hB00, 12'h02D, 12'h030, 12'h200, 12'h4F0};
`else
  logic [W+3:0] d_exp [11] = '{12'h580, 12'hA00, 12'h4FF, 12'h802, 12'h4F0, 12'h200,
                               12'hB00, 12'h02D, 12'h030, 12'h200, 12'h4F0};
`endif
  int d_hold [11] = '{0, 0, 1, 0, 2, 0, 0, 1, 5, 0, 0};

  initial begin
    logic [3:0]   o;
    logic [W-1:0] x, y;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      drive_accept(d_op[i], d_a[i], d_b[i], d_exp[i]);
      wait_result((d_op[i] == 4'hB) ? W + 1 : 1);
      consume(d_hold[i]);
    end

    // out_ready and a new in_valid together in DONE: only the result moves
    drive_accept(4'h4, 8'hAA, 8'h0F, model(4'h4, 8'hAA, 8'h0F));
    wait_result(1);
    check_outputs();
    op = 4'h6; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("overlap_valid", out_valid, 0);
    check_val("overlap_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(4'h6, 8'h01, 8'h02));
    check_val("overlap_accept_ready", in_ready, 0);
    check_val("overlap_accept_valid", out_valid, 1);
    consume(0);

    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 11));
      drive_accept(o, x, y, model(o, x, y));
      wait_result((o == 4'hB) ? W + 1 : 1);
      consume($urandom_range(0, 3));
    end

    // reset on the 4th BUSY cycle of a MUL: no partial result may appear
    drive_accept(4'h3, 8'h5A, 8'h81, model(4'h3, 8'h5A, 8'h81));
    wait_result(1);
    consume(0);
    drive_accept(4'hB, 8'h0F, 8'h03, 12'h02D);
    exp_q.delete();
    repeat (3) tick();
    check_val("mul_mid_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("mul_reset");
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check_val("after_reset_valid", out_valid, 0);
    end

    // reset while a result is held in DONE
    drive_accept(4'h3, 8'hF0, 8'h0F, 12'h4FF);
    wait_result(1);
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("done_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
